// File: rtl/scsi_inq_capture.sv
// Captures matching SCSI inquiry frames and packs 64-bit words into 128-bit beats.
// Corrupt, oversized or truncated sets are flushed downstream and counted as drops.
module scsi_inq_capture #(
  parameter int MAX_WORDS  = 16,
  parameter int GAP_CYCLES = 3
) (
  input  logic         iCLK,
  input  logic         iRST,
  input  logic         iVALID,
  input  logic         iSOF,
  input  logic         iEOF,
  input  logic [63:0]  iDATA,
  input  logic         iINQ_MATCH,
  input  logic         iCRC_ERR,
  input  logic         iINQ_BUFFER_BUSY,
  output logic [127:0] oINQ_DATA,
  output logic [1:0]   oWR_BANK_SLOT,
  output logic         oSTART_SET,
  output logic         oEND_SET,
  output logic         oFLUSH,
  output logic [15:0]  oDROP_CNT
);

  localparam int CntW = $clog2(MAX_WORDS + 1);
  localparam int GapW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, CAPT, DISCARD, GAP} state_t;

  state_t          state;
  logic [CntW-1:0] wordCnt;
  logic [GapW-1:0] gapCnt;
  logic [63:0]     laneLo;
  logic            haveLo;

  // First pipeline stage: the beat (or flush) produced by the word accepted last cycle.
  logic [127:0]    s1Data;
  logic [1:0]      s1Slot;
  logic            s1End;
  logic            s1Flush;

  logic            sofW;
  logic            eofW;
  logic            overflow;
  logic            dropEvt;

  assign sofW     = iVALID & iSOF;
  assign eofW     = iVALID & iEOF;
  assign overflow = (wordCnt == CntW'(MAX_WORDS));

  // A SOF arriving during GAP is refused exactly as if the buffer were busy.
  always_comb begin
    dropEvt = 1'b0;
    case (state)
      IDLE:    dropEvt = sofW & iINQ_MATCH & iINQ_BUFFER_BUSY;
      GAP:     dropEvt = sofW & iINQ_MATCH;
      CAPT:    dropEvt = iVALID & (iSOF | overflow | (iEOF & iCRC_ERR));
      default: dropEvt = 1'b0;
    endcase
  end

  always_ff @(posedge iCLK) begin
    // NOTE: the synchronous reset also clears the lane and stage-1 data registers so an
    // aborted frame can never leak a stale beat or pulse after reset is released.
    if (iRST) begin
      state      <= IDLE;
      wordCnt    <= '0;
      gapCnt     <= '0;
      laneLo     <= '0;
      haveLo     <= 1'b0;
      s1Data     <= '0;
      s1Slot     <= 2'b00;
      s1End      <= 1'b0;
      s1Flush    <= 1'b0;
      oSTART_SET <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults first, then overrides below; the last assignment
      // in program order wins, so every pulse is one cycle wide without extra logic.
      s1Data     <= '0;
      s1Slot     <= 2'b00;
      s1End      <= 1'b0;
      s1Flush    <= 1'b0;
      oSTART_SET <= 1'b0;

      case (state)
        IDLE: begin
          if (sofW) begin
            if (iINQ_MATCH && !iINQ_BUFFER_BUSY) begin
              oSTART_SET <= 1'b1;
              wordCnt    <= CntW'(1);
              laneLo     <= iDATA;
              haveLo     <= ~iEOF;
              if (iEOF) begin
                state  <= GAP;
                gapCnt <= GapW'(GAP_CYCLES);
                if (iCRC_ERR) begin
                  s1Flush <= 1'b1;
                end else begin
                  s1Data <= {64'd0, iDATA};
                  s1Slot <= 2'b01;
                  s1End  <= 1'b1;
                end
              end else begin
                state <= CAPT;
              end
            end else if (!iEOF) begin
              state <= DISCARD;
            end
          end
        end

        CAPT: begin
          if (iVALID) begin
            if (iSOF || overflow) begin
              // Truncated or oversized set: the offending word is never emitted.
              s1Flush <= 1'b1;
              haveLo  <= 1'b0;
              if (iEOF) begin
                state  <= GAP;
                gapCnt <= GapW'(GAP_CYCLES);
              end else begin
                state <= DISCARD;
              end
            end else begin
              wordCnt <= wordCnt + 1'b1;
              if (iEOF) begin
                state  <= GAP;
                gapCnt <= GapW'(GAP_CYCLES);
                haveLo <= 1'b0;
                if (iCRC_ERR) begin
                  s1Flush <= 1'b1;
                end else begin
                  s1End <= 1'b1;
                  if (haveLo) begin
                    s1Data <= {iDATA, laneLo};
                    s1Slot <= 2'b11;
                  end else begin
                    s1Data <= {64'd0, iDATA};
                    s1Slot <= 2'b01;
                  end
                end
              end else if (haveLo) begin
                s1Data <= {iDATA, laneLo};
                s1Slot <= 2'b11;
                haveLo <= 1'b0;
              end else begin
                laneLo <= iDATA;
                haveLo <= 1'b1;
              end
            end
          end
        end

        DISCARD: begin
          if (eofW) begin
            state  <= GAP;
            gapCnt <= GapW'(GAP_CYCLES);
          end
        end

        GAP: begin
          if (sofW && !iEOF) begin
            state <= DISCARD;
          end else if (gapCnt == '0) begin
            state <= IDLE;
          end else begin
            gapCnt <= gapCnt - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Second pipeline stage drives the registered outputs.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oINQ_DATA     <= '0;
      oWR_BANK_SLOT <= 2'b00;
      oEND_SET      <= 1'b0;
      oFLUSH        <= 1'b0;
    end else begin
      oINQ_DATA     <= s1Data;
      oWR_BANK_SLOT <= s1Slot;
      oEND_SET      <= s1End;
      oFLUSH        <= s1Flush;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oDROP_CNT <= '0;
    end else if (dropEvt && (oDROP_CNT != 16'hFFFF)) begin
      oDROP_CNT <= oDROP_CNT + 16'd1;
    end
  end

endmodule

// File: tb/tb_scsi_inq_capture.sv
// Bench for scsi_inq_capture: table of frame scenarios with per-row expected totals,
// plus a scoreboard of expected beats/pulses with their exact output cycles.
module tb_scsi_inq_capture;

  localparam int MAXW = 16;
  localparam int GAP  = 3;

  logic         iCLK;
  logic         iRST;
  logic         iVALID;
  logic         iSOF;
  logic         iEOF;
  logic [63:0]  iDATA;
  logic         iINQ_MATCH;
  logic         iCRC_ERR;
  logic         iINQ_BUFFER_BUSY;
  logic [127:0] oINQ_DATA;
  logic [1:0]   oWR_BANK_SLOT;
  logic         oSTART_SET;
  logic         oEND_SET;
  logic         oFLUSH;
  logic [15:0]  oDROP_CNT;

  scsi_inq_capture #(.MAX_WORDS(MAXW), .GAP_CYCLES(GAP)) dut (
    .iCLK             (iCLK),
    .iRST             (iRST),
    .iVALID           (iVALID),
    .iSOF             (iSOF),
    .iEOF             (iEOF),
    .iDATA            (iDATA),
    .iINQ_MATCH       (iINQ_MATCH),
    .iCRC_ERR         (iCRC_ERR),
    .iINQ_BUFFER_BUSY (iINQ_BUFFER_BUSY),
    .oINQ_DATA        (oINQ_DATA),
    .oWR_BANK_SLOT    (oWR_BANK_SLOT),
    .oSTART_SET       (oSTART_SET),
    .oEND_SET         (oEND_SET),
    .oFLUSH           (oFLUSH),
    .oDROP_CNT        (oDROP_CNT)
  );

  typedef struct {
    int n; bit match; bit busy; bit crc; bit stall; int sofAt; int pre;
    int expBeats; int expEnd; int expFlush; int expDrop;
  } vec_t;

  typedef struct {
    int cyc; logic [127:0] data; logic [1:0] slot; bit endSet; bit flush;
  } ev_t;

  vec_t vecs[13];
  ev_t  evQ[$];
  int   startQ[$];
  int   cyc = 0;
  int   lastEnd;
  int   testsRun = 0;
  int   testsFailed = 0;
  int   rowBeats, rowEnds, rowFlushes;

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Compare everything the DUT shows in the current cycle against the scoreboard.
  task automatic monitorStep();
    ev_t e;
    int  s;
    check("pulse_exclusive", $countones({oSTART_SET, oEND_SET, oFLUSH}) <= 1, 1);
    if (oSTART_SET) begin
      check("start_expected", startQ.size() != 0, 1);
      if (startQ.size() != 0) begin
        s = startQ.pop_front();
        check("start_cycle", cyc, s);
      end
    end
    if (oWR_BANK_SLOT != 2'b00 || oEND_SET || oFLUSH) begin
      if (oWR_BANK_SLOT != 2'b00) rowBeats++;
      if (oEND_SET) rowEnds++;
      if (oFLUSH) rowFlushes++;
      check("event_expected", evQ.size() != 0, 1);
      if (evQ.size() != 0) begin
        e = evQ.pop_front();
        check("event_cycle", cyc, e.cyc);
        check("beat_data", oINQ_DATA, e.data);
        check("beat_slot", oWR_BANK_SLOT, e.slot);
        check("end_set", oEND_SET, e.endSet);
        check("flush", oFLUSH, e.flush);
      end
    end else begin
      check("idle_data_zero", oINQ_DATA, 0);
    end
  endtask

  task automatic tick();
    @(negedge iCLK);
    monitorStep();
  endtask

  task automatic driveIdle();
    iVALID = 1'b0; iSOF = 1'b0; iEOF = 1'b0; iDATA = '0;
    iINQ_MATCH = 1'b0; iCRC_ERR = 1'b0; iINQ_BUFFER_BUSY = 1'b0;
  endtask

  task automatic pushEv(input int c, input logic [127:0] d, input logic [1:0] s,
                        input bit en, input bit fl);
    ev_t e;
    e.cyc = c; e.data = d; e.slot = s; e.endSet = en; e.flush = fl;
    evQ.push_back(e);
  endtask

  // Drives one frame and predicts its outputs: beats land 2 cycles after the
  // word that completes them, START 1 cycle after the SOF.
  task automatic sendFrame(input vec_t v);
    logic [63:0] w, prev;
    bit alive;
    int a;
    alive = 1'b0;
    prev  = '0;
    for (int i = 0; i < v.n; i++) begin
      if (v.stall && i == 2) begin
        tick();
        iVALID = 1'b0; iSOF = 1'b1; iEOF = 1'b1; iDATA = {$urandom(), $urandom()};
        iINQ_MATCH = 1'b1; iCRC_ERR = 1'b1; iINQ_BUFFER_BUSY = 1'b0;
      end
      tick();
      a = cyc;
      w = {$urandom(), $urandom()};
      iVALID = 1'b1;
      iDATA  = w;
      iSOF   = (i == 0) || (v.sofAt != 0 && i == v.sofAt);
      iEOF   = (i == v.n - 1);
      iINQ_MATCH       = (i == 0) ? v.match : 1'($urandom());
      iINQ_BUFFER_BUSY = (i == 0) ? v.busy  : 1'($urandom());
      iCRC_ERR         = (i == v.n - 1) ? v.crc : 1'($urandom());
      if (i == 0) begin
        alive = v.match && !v.busy && (a >= lastEnd + GAP);
        if (alive) startQ.push_back(a + 1);
      end
      if (alive) begin
        if (i != 0 && ((v.sofAt != 0 && i == v.sofAt) || i >= MAXW)) begin
          pushEv(a + 2, '0, 2'b00, 1'b0, 1'b1);
          alive = 1'b0;
        end else if (i == v.n - 1) begin
          if (v.crc) pushEv(a + 2, '0, 2'b00, 1'b0, 1'b1);
          else if (i % 2 == 1) pushEv(a + 2, {w, prev}, 2'b11, 1'b1, 1'b0);
          else pushEv(a + 2, {64'd0, w}, 2'b01, 1'b1, 1'b0);
        end else if (i % 2 == 1) begin
          pushEv(a + 2, {w, prev}, 2'b11, 1'b0, 1'b0);
        end else begin
          prev = w;
        end
      end
      if (i == v.n - 1) lastEnd = a + 2;
    end
  endtask

  task automatic finishRow(input vec_t v, input string name);
    repeat (2) begin
      tick();
      driveIdle();
    end
    check({name, "_beats"},   rowBeats,   v.expBeats);
    check({name, "_ends"},    rowEnds,    v.expEnd);
    check({name, "_flushes"}, rowFlushes, v.expFlush);
    check({name, "_drops"},   oDROP_CNT,  v.expDrop);
    rowBeats = 0; rowEnds = 0; rowFlushes = 0;
  endtask

  task automatic checkAllZero(input string name);
    check({name, "_data"},  oINQ_DATA, 0);
    check({name, "_slot"},  oWR_BANK_SLOT, 0);
    check({name, "_start"}, oSTART_SET, 0);
    check({name, "_end"},   oEND_SET, 0);
    check({name, "_flush"}, oFLUSH, 0);
    check({name, "_drops"}, oDROP_CNT, 0);
  endtask

  initial begin
    vec_t clean;
    //            n  m  b  c  st sof pre  beats end flush drop
    vecs[0]  = '{ 4, 1, 0, 0, 0, 0,  3,   2,    1,  0,    0};
    vecs[1]  = '{ 1, 1, 0, 0, 0, 0,  3,   1,    1,  0,    0};
    vecs[2]  = '{ 3, 1, 0, 1, 0, 0,  3,   1,    0,  1,    1};
    vecs[3]  = '{17, 1, 0, 0, 0, 0,  3,   8,    0,  1,    2};
    vecs[4]  = '{ 5, 1, 0, 0, 1, 0,  3,   3,    1,  0,    2};
    vecs[5]  = '{ 3, 1, 1, 0, 0, 0,  3,   0,    0,  0,    3};
    vecs[6]  = '{ 3, 0, 0, 0, 0, 0,  3,   0,    0,  0,    3};
    vecs[7]  = '{ 2, 1, 0, 0, 0, 0,  3,   1,    1,  0,    3};
    vecs[8]  = '{ 4, 1, 0, 0, 0, 0,  0,   0,    0,  0,    4};
    vecs[9]  = '{16, 1, 0, 0, 0, 0,  2,   8,    1,  0,    4};
    vecs[10] = '{ 2, 1, 0, 0, 0, 0,  1,   0,    0,  0,    5};
    vecs[11] = '{ 6, 1, 0, 1, 0, 0,  2,   2,    0,  1,    6};
    vecs[12] = '{ 5, 1, 0, 0, 0, 2,  3,   1,    0,  1,    7};
    clean    = '{ 4, 1, 0, 0, 0, 0,  0,   2,    1,  0,    0};

    rowBeats = 0; rowEnds = 0; rowFlushes = 0;
    lastEnd = -1000;
    iRST = 1'b1;
    driveIdle();
    repeat (3) tick();
    checkAllZero("reset");
    iRST = 1'b0;

    for (int r = 0; r < 13; r++) begin
      repeat (vecs[r].pre) begin
        tick();
        driveIdle();
      end
      sendFrame(vecs[r]);
      finishRow(vecs[r], $sformatf("row%0d", r));
    end

    // Reset after word 2 of a 4-word frame: nothing from that frame may appear.
    repeat (4) begin
      tick();
      driveIdle();
    end
    tick();
    iVALID = 1'b1; iSOF = 1'b1; iINQ_MATCH = 1'b1; iDATA = 64'hA;
    startQ.push_back(cyc + 1);
    tick();
    iSOF = 1'b0; iINQ_MATCH = 1'b0; iDATA = 64'hB;
    tick();
    driveIdle();
    iRST = 1'b1;
    tick();
    checkAllZero("midreset");
    iRST = 1'b0;
    iVALID = 1'b1; iDATA = 64'hC;
    tick();
    iEOF = 1'b1; iDATA = 64'hD;
    tick();
    driveIdle();
    repeat (4) begin
      tick();
      driveIdle();
    end
    check("midreset_no_output", rowBeats + rowEnds + rowFlushes, 0);
    lastEnd = -1000;
    sendFrame(clean);
    finishRow(clean, "after_reset");

    repeat (4) begin
      tick();
      driveIdle();
    end
    check("events_left", evQ.size(), 0);
    check("starts_left", startQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/scsi_inq_capture.md
SCSI_INQ_CAPTURE -- requirements
Module: scsi_inq_capture

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 16, maximum 64-bit words per captured inquiry set (16 words fill a 8x128b buffer).
REQ-002 SHALL have parameter GAP_CYCLES, default 3, cycles after a set ends during which no new set is started.
REQ-003 iCLK  in  1  single clock; all logic on rising edge.
REQ-004 iRST  in  1  reset, synchronous, active-high.
REQ-005 iVALID  in  1  input word qualifier.
REQ-006 iSOF  in  1  first word of frame (qualified by iVALID).
REQ-007 iEOF  in  1  last word of frame (qualified by iVALID); iSOF&iEOF legal (1-word frame).
REQ-008 iDATA  in  64  frame word.
REQ-009 iINQ_MATCH  in  1  sampled with SOF word; frame is a SCSI inquiry to capture.
REQ-010 iCRC_ERR  in  1  sampled with EOF word; frame corrupt.
REQ-011 iINQ_BUFFER_BUSY  in  1  downstream inquiry buffer busy.
REQ-012 oINQ_DATA  out  128  packed beat; word n in [63:0], word n+1 in [127:64].
REQ-013 oWR_BANK_SLOT  out  2  per-half valid for oINQ_DATA; 00 = no beat.
REQ-014 oSTART_SET  out  1  one-cycle pulse, set begins.
REQ-015 oEND_SET  out  1  one-cycle pulse, coincident with final beat.
REQ-016 oFLUSH  out  1  one-cycle pulse, discard partial set downstream.
REQ-017 oDROP_CNT  out  16  saturating count of dropped matching frames.

Function
REQ-018 States SHALL be IDLE, CAPT, DISCARD, GAP.
REQ-019 IDLE: valid SOF with iINQ_MATCH=1 and iINQ_BUFFER_BUSY=0 -> CAPT; with iINQ_MATCH=1 and busy=1 -> DISCARD, oDROP_CNT+1; iINQ_MATCH=0 -> DISCARD, no count; non-SOF words ignored.
REQ-020 oSTART_SET SHALL pulse at cycle t+1 for a SOF accepted into CAPT at cycle t.
REQ-021 CAPT: valid words packed in pairs, SOF word in lane 0; lane pairing restarts each frame.
REQ-022 A beat SHALL appear on oINQ_DATA/oWR_BANK_SLOT exactly 2 cycles after the cycle its last contributing word was accepted (2-stage pipeline); first beat therefore always after oSTART_SET.
REQ-023 Odd-length frame: final beat slot=01, [127:64]=0; unused halves always driven 0.
REQ-024 Clean EOF (iCRC_ERR=0): oEND_SET asserted on final beat cycle -> GAP.
REQ-025 EOF with iCRC_ERR=1: final beat suppressed (slot=00), oFLUSH instead of oEND_SET on that cycle, oDROP_CNT+1 -> GAP.
REQ-026 Word count exceeding MAX_WORDS: offending word not emitted; oFLUSH pulses 2 cycles after it; oDROP_CNT+1; -> DISCARD (or GAP if that word has EOF).
REQ-027 SOF in CAPT (missing EOF): oFLUSH 2 cycles later, oDROP_CNT+1, new frame not captured -> DISCARD (or GAP if also EOF).
REQ-028 DISCARD: no beats/pulses; on valid EOF -> GAP.
REQ-029 GAP: held GAP_CYCLES cycles counted from END_SET/FLUSH cycle, busy ignored (covers downstream busy latency); SOF during GAP treated as busy (REQ-019 busy branch, DISCARD); then -> IDLE.
REQ-030 iVALID=0 cycles SHALL not advance packing or counts; pipeline still drains.
REQ-031 oDROP_CNT SHALL saturate at 16'hFFFF.
REQ-032 oSTART_SET, oEND_SET, oFLUSH mutually exclusive in any cycle.

Reset
REQ-033 iRST=1 SHALL force IDLE, clear pipeline, oINQ_DATA=0, oWR_BANK_SLOT=00, all pulses 0, oDROP_CNT=0 on next edge.
REQ-034 Reset mid-frame: remaining words ignored until next SOF; no oEND_SET/oFLUSH generated for the aborted frame.

Verification
REQ-035 4-word match frame A..D at t..t+3 -> oSTART_SET t+1; beats {B,A} slot 11 at t+3, {D,C} slot 11 with oEND_SET at t+5.
REQ-036 1-word frame (SOF&EOF, X) at t -> oSTART_SET t+1; {0,X} slot 01 with oEND_SET at t+2.
REQ-037 3-word frame, iCRC_ERR=1 on EOF -> one beat slot 11, then oFLUSH (no oEND_SET) on final-beat cycle; oDROP_CNT=1.
REQ-038 17-word frame, MAX_WORDS=16 -> 8 beats, oFLUSH 2 cycles after word 17, no oEND_SET, oDROP_CNT=1.
REQ-039 Match SOF with iINQ_BUFFER_BUSY=1, then SOF 1 cycle after a prior oEND_SET -> both frames dropped, oDROP_CNT=2, no outputs.
REQ-040 iRST asserted after word 2 of 4-word frame -> all outputs 0, no pulses; next clean frame captured normally.
